// File: rtl/ofdm_symbol_sequencer.sv
// OFDM symbol sequencer: maps a QAM sample stream plus nulls and BPSK pilots
// onto the 64 IFFT bins of each symbol, with ready/valid on both sides.
module ofdm_symbol_sequencer #(
    parameter int unsigned       N_FFT     = 64,
    parameter logic signed [15:0] PILOT_AMP = 16'sd8192
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic signed [15:0] data_i,
    input  logic signed [15:0] data_q,
    input  logic               data_valid,
    output logic               data_ready,
    output logic signed [15:0] out_i,
    output logic signed [15:0] out_q,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [5:0]         out_bin,
    output logic               sop,
    output logic               eop,
    output logic [15:0]        sym_cnt,
    output logic               busy
);

    localparam int unsigned        BIN_W     = 6;
    localparam int unsigned        LFSR_W    = 7;
    localparam logic [BIN_W-1:0]   LAST_BIN  = BIN_W'(N_FFT - 1);
    localparam logic [LFSR_W-1:0]  LFSR_SEED = 7'b1111111;
    localparam logic signed [15:0] PILOT_NEG = -PILOT_AMP;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]        state;
    logic [0:0]        state_next;
    logic [BIN_W-1:0]  k;
    logic [LFSR_W-1:0] lfsr;

    logic              bin_null;
    logic              bin_pilot;
    logic              bin_data;
    logic              run;
    logic              out_free;
    logic              load;
    logic              xfer_last;
    logic              pol_fb;
    logic              pilot_neg;
    logic signed [15:0] bin_i;
    logic signed [15:0] bin_q;

    // Bin classification for the current bin counter
    always_comb begin
        bin_null  = (k == 6'd0) || ((k >= 6'd27) && (k <= 6'd37));
        bin_pilot = (k == 6'd7) || (k == 6'd21) || (k == 6'd43) || (k == 6'd57);
        bin_data  = !bin_null && !bin_pilot;
    end

    // Handshake and load qualification; reset masks everything
    always_comb begin
        run        = (state == S_RUN) && !reset;
        out_free   = !out_valid || out_ready;
        data_ready = run && enable && bin_data && out_free;
        load       = run && enable && out_free && (!bin_data || data_valid);
        xfer_last  = out_valid && out_ready && (out_bin == LAST_BIN);
        busy       = run;
    end

    // Pilot polarity is frozen for the symbol; bin 21 carries the inverted pilot
    always_comb begin
        pol_fb    = lfsr[6] ^ lfsr[3];
        pilot_neg = pol_fb ^ (k == 6'd21);
        bin_i     = 16'sd0;
        bin_q     = 16'sd0;
        if (bin_pilot) begin
            bin_i = pilot_neg ? PILOT_NEG : PILOT_AMP;
        end else if (bin_data) begin
            bin_i = data_i;
            bin_q = data_q;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (enable) state_next = S_RUN;
            S_RUN:   if (xfer_last && !enable) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Output register, bin counter, pilot LFSR and symbol counter
    always_ff @(posedge clock) begin
        if (reset) begin
            k         <= '0;
            lfsr      <= LFSR_SEED;
            out_valid <= 1'b0;
            out_i     <= 16'sd0;
            out_q     <= 16'sd0;
            out_bin   <= '0;
            sop       <= 1'b0;
            eop       <= 1'b0;
            sym_cnt   <= 16'd0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_i     <= bin_i;
            out_q     <= bin_q;
            out_bin   <= k;
            sop       <= (k == 6'd0);
            eop       <= (k == LAST_BIN);
            k         <= k + 6'd1;
            if (k == LAST_BIN) begin
                lfsr    <= {lfsr[5:0], pol_fb};
                sym_cnt <= sym_cnt + 16'd1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ofdm_symbol_sequencer.sv
// Directed bench for ofdm_symbol_sequencer: throughput, bin map, pilot
// polarity, backpressure, starvation, enable stall and mid-symbol reset.
module tb_ofdm_symbol_sequencer;

    logic               clock;
    logic               reset;
    logic               enable;
    logic signed [15:0] data_i;
    logic signed [15:0] data_q;
    logic               data_valid;
    logic               data_ready;
    logic signed [15:0] out_i;
    logic signed [15:0] out_q;
    logic               out_valid;
    logic               out_ready;
    logic [5:0]         out_bin;
    logic               sop;
    logic               eop;
    logic [15:0]        sym_cnt;
    logic               busy;

    ofdm_symbol_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .data_i     (data_i),
        .data_q     (data_q),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .out_i      (out_i),
        .out_q      (out_q),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bin    (out_bin),
        .sop        (sop),
        .eop        (eop),
        .sym_cnt    (sym_cnt),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Pilot polarity per symbol from the 7-bit LFSR seeded with all ones
    int pol_tab [8] = '{1, 1, 1, 1, -1, -1, -1, 1};

    int          q_bin [$];
    int          q_sop [$];
    int          q_eop [$];
    int          q_cyc [$];
    logic [31:0] q_iq  [$];

    int ramp       = 1;
    int cyc        = 0;
    int dr_pulses  = 0;
    int last_xfer  = 0;
    int last_bin   = -1;
    int exp_k      = 0;
    int exp_sym    = 0;
    int exp_d      = 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_iq(input int kk, input int sym, input int d);
        logic [15:0] ei;
        logic [15:0] eq;
        logic        neg;
        ei = 16'h0000;
        eq = 16'h0000;
        if (kk == 0 || (kk >= 27 && kk <= 37)) begin
            ei = 16'h0000;
        end else if (kk == 7 || kk == 21 || kk == 43 || kk == 57) begin
            neg = (pol_tab[sym] < 0) ^ (kk == 21);
            ei  = neg ? 16'hE000 : 16'h2000;
        end else begin
            ei = 16'(d);
            eq = 16'(-d);
        end
        return {ei, eq};
    endfunction

    function automatic bit is_data(input int kk);
        return !(kk == 0 || (kk >= 27 && kk <= 37) ||
                 kk == 7 || kk == 21 || kk == 43 || kk == 57);
    endfunction

    // One clock: observe at the falling edge, update the QAM source after the rising edge
    task automatic cycle();
        logic hs;
        @(negedge clock);
        last_xfer = 0;
        if (data_ready) dr_pulses++;
        hs = data_ready && data_valid;
        if (out_valid && out_ready) begin
            q_bin.push_back(int'(out_bin));
            q_sop.push_back(int'(sop));
            q_eop.push_back(int'(eop));
            q_cyc.push_back(cyc);
            q_iq.push_back({out_i, out_q});
            last_xfer = 1;
            last_bin  = int'(out_bin);
        end
        @(posedge clock);
        #1;
        cyc++;
        if (hs) begin
            ramp++;
            data_i = 16'(ramp);
            data_q = 16'(-ramp);
        end
    endtask

    task automatic run_until_bin(input int b);
        logic found;
        found = 1'b0;
        for (int n = 0; n < 300 && !found; n++) begin
            cycle();
            if (last_xfer == 1 && last_bin == b) found = 1'b1;
        end
        check_eq("reach_bin", 32'(found), 32'd1);
    endtask

    // Walk recorded transfers against the expected bin sequence
    task automatic verify();
        int b;
        while (q_bin.size() > 0) begin
            b = q_bin.pop_front();
            check_eq("bin", 32'(b), 32'(exp_k));
            check_eq("sop", 32'(q_sop.pop_front()), 32'(exp_k == 0));
            check_eq("eop", 32'(q_eop.pop_front()), 32'(exp_k == 63));
            check_eq("iq", q_iq.pop_front(), exp_iq(exp_k, exp_sym, exp_d));
            void'(q_cyc.pop_front());
            if (is_data(exp_k)) exp_d++;
            exp_k = (exp_k + 1) % 64;
            if (exp_k == 0) exp_sym++;
        end
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b1;
        data_valid = 1'b1;
        out_ready  = 1'b1;
        data_i     = 16'sd1;
        data_q     = -16'sd1;

        // Reset state with all other inputs asserted
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_iq", {out_i, out_q}, 32'd0);
        check_eq("rst_out_bin", 32'(out_bin), 32'd0);
        check_eq("rst_sop_eop", {30'd0, sop, eop}, 32'd0);
        check_eq("rst_sym_cnt", 32'(sym_cnt), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_data_ready", 32'(data_ready), 32'd0);
        @(posedge clock);
        #1;
        enable = 1'b0;
        reset  = 1'b0;
        cycle();
        check_eq("idle_busy", 32'(busy), 32'd0);

        // Full-throughput symbol 0
        dr_pulses = 0;
        enable = 1'b1;
        run_until_bin(62);
        enable = 1'b0;
        repeat (3) cycle();
        check_eq("s0_xfer_count", 32'(q_bin.size()), 32'd64);
        if (q_cyc.size() == 64) check_eq("s0_consecutive", 32'(q_cyc[63] - q_cyc[0]), 32'd63);
        check_eq("s0_data_ready_pulses", 32'(dr_pulses), 32'd48);
        check_eq("s0_sym_cnt", 32'(sym_cnt), 32'd1);
        check_eq("s0_busy", 32'(busy), 32'd0);
        check_eq("s0_out_valid", 32'(out_valid), 32'd0);
        verify();

        // Symbols 1..4 back to back; symbol 4 flips pilot polarity
        enable = 1'b1;
        repeat (4) run_until_bin(62);
        enable = 1'b0;
        repeat (3) cycle();
        check_eq("s4_sym_cnt", 32'(sym_cnt), 32'd5);
        verify();

        // Symbol 5: backpressure at bin 10 (data sample 249)
        enable = 1'b1;
        run_until_bin(9);
        out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clock);
            check_eq("bp_out_valid", 32'(out_valid), 32'd1);
            check_eq("bp_out_bin", 32'(out_bin), 32'd10);
            check_eq("bp_data_ready", 32'(data_ready), 32'd0);
            check_eq("bp_iq", {out_i, out_q}, 32'h00F9_FF07);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;

        // Starvation from bin 30: nulls run through, stall at data bin 38
        run_until_bin(29);
        data_valid = 1'b0;
        repeat (12) cycle();
        check_eq("starve_out_valid", 32'(out_valid), 32'd0);
        check_eq("starve_data_ready", 32'(data_ready), 32'd1);
        check_eq("starve_last_bin", 32'(last_bin), 32'd37);
        data_valid = 1'b1;

        // Enable drop at bin 40: bin 40 drains, nothing more loads
        run_until_bin(39);
        enable = 1'b0;
        repeat (5) cycle();
        check_eq("en_out_valid", 32'(out_valid), 32'd0);
        check_eq("en_data_ready", 32'(data_ready), 32'd0);
        check_eq("en_busy", 32'(busy), 32'd1);
        check_eq("en_last_bin", 32'(last_bin), 32'd40);
        enable = 1'b1;
        run_until_bin(62);
        enable = 1'b0;
        repeat (3) cycle();
        check_eq("s5_busy", 32'(busy), 32'd0);
        check_eq("s5_sym_cnt", 32'(sym_cnt), 32'd6);
        verify();

        // Symbol 6 interrupted by reset while bin 20 is in the output register
        enable = 1'b1;
        run_until_bin(19);
        verify();
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clock);
        check_eq("mid_rst_data_ready", 32'(data_ready), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check_eq("post_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("post_rst_sym_cnt", 32'(sym_cnt), 32'd0);
        check_eq("post_rst_busy", 32'(busy), 32'd0);
        @(posedge clock);
        #1;
        exp_k   = 0;
        exp_sym = 0;
        exp_d   = ramp;
        enable  = 1'b1;
        run_until_bin(62);
        enable = 1'b0;
        repeat (3) cycle();
        check_eq("r_sym_cnt", 32'(sym_cnt), 32'd1);
        check_eq("r_busy", 32'(busy), 32'd0);
        check_eq("r_xfer_count", 32'(q_bin.size()), 32'd64);
        verify();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
